uart_wb_burst_bridge: RTL

Byte-stream to Wishbone master bridge with burst support. A host link (UART byte interface, valid/ready) sends framed read/write commands. The bridge issues one classic single Wishbone cycle per word with an auto-incrementing address, bus timeout and error capture, and returns a status byte per frame. It sits between the UART rx/tx cores and the system Wishbone bus, as the next-generation debug/boot loader path.

---
 rtl/uart_wb_burst_bridge.sv | 291 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_wb_burst_bridge.sv
// Byte-stream to Wishbone master bridge: framed read/write bursts from a UART link,
// one classic Wishbone cycle per word, one status byte returned per frame.
module uart_wb_burst_bridge #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned WB_TIMEOUT = 255,
  parameter int unsigned RX_TIMEOUT = 100000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic                    rx_ready,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i,
  output logic                    busy
);

  localparam int unsigned BYTES   = DATA_WIDTH / 8;
  localparam int unsigned ABYTES  = ADDR_WIDTH / 8;
  localparam int unsigned WbCntW  = $clog2(WB_TIMEOUT + 1);
  localparam int unsigned RxCntW  = $clog2(RX_TIMEOUT + 1);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StAddr     = 3'd1;
  localparam logic [2:0] StLen      = 3'd2;
  localparam logic [2:0] StWdata    = 3'd3;
  localparam logic [2:0] StWbAcc    = 3'd4;
  localparam logic [2:0] StTxData   = 3'd5;
  localparam logic [2:0] StTxStatus = 3'd6;

  localparam logic [7:0] CmdRead  = 8'h01;
  localparam logic [7:0] CmdWrite = 8'hAA;
  localparam logic [7:0] StatOk   = 8'h00;
  localparam logic [7:0] StatErr  = 8'hE0;
  localparam logic [7:0] StatTmo  = 8'hE1;
  localparam logic [7:0] StatLen  = 8'hE2;

  logic [2:0]            state_q, state_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            word_q, word_d;
  logic [7:0]            idx_q, idx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [7:0]            status_q, status_d;
  logic                  cyc_q, cyc_d;
  logic [WbCntW-1:0]     wb_cnt_q, wb_cnt_d;
  logic [RxCntW-1:0]     rx_cnt_q, rx_cnt_d;

  logic                  rx_state;
  logic                  rx_fire;
  logic                  tx_fire;
  logic                  last_abyte;
  logic                  last_dbyte;
  logic                  last_word;
  logic                  acc_done;
  logic [ADDR_WIDTH-1:0] addr_next;

  assign rx_state   = (state_q == StAddr) || (state_q == StLen) || (state_q == StWdata) ||
                      (state_q == StIdle);
  assign rx_ready   = rx_state && !rst;
  assign rx_fire    = rx_valid && rx_ready;
  assign tx_valid   = (state_q == StTxData) || (state_q == StTxStatus);
  assign tx_fire    = tx_valid && tx_ready;
  assign last_abyte = idx_q == 8'(ABYTES - 1);
  assign last_dbyte = idx_q == 8'(BYTES - 1);
  assign last_word  = word_q == len_q;
  assign addr_next  = addr_q + ADDR_WIDTH'(BYTES);

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    addr_d   = addr_q;
    len_d    = len_q;
    word_d   = word_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    status_d = status_q;
    cyc_d    = cyc_q;
    wb_cnt_d = wb_cnt_q;
    rx_cnt_d = rx_cnt_q;
    acc_done = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rx_fire && (rx_data == CmdRead || rx_data == CmdWrite)) begin
          write_d  = rx_data == CmdWrite;
          addr_d   = '0;
          len_d    = '0;
          word_d   = '0;
          idx_d    = '0;
          wdata_d  = '0;
          rdata_d  = '0;
          status_d = StatOk;
          state_d  = StAddr;
        end
      end

      StAddr: begin
        if (rx_fire) begin
          addr_d[8*idx_q +: 8] = rx_data;
          if (last_abyte) begin
            idx_d   = '0;
            state_d = StLen;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end

      StLen: begin
        if (rx_fire) begin
          len_d = rx_data;
          // LEN+1 > MAX_BURST, done in 9 bits so MAX_BURST=256 fits
          if ({1'b0, rx_data} >= 9'(MAX_BURST)) begin
            status_d = StatLen;
            state_d  = StTxStatus;
          end else if (write_q) begin
            state_d = StWdata;
          end else begin
            cyc_d    = 1'b1;
            wb_cnt_d = '0;
            state_d  = StWbAcc;
          end
        end
      end

      StWdata: begin
        if (rx_fire) begin
          wdata_d[8*idx_q +: 8] = rx_data;
          if (last_dbyte) begin
            idx_d = '0;
            if (status_q == StatOk) begin
              cyc_d    = 1'b1;
              wb_cnt_d = '0;
              state_d  = StWbAcc;
            end else begin
              acc_done = 1'b1;
            end
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end

      StWbAcc: begin
        if (wb_ack_i) begin
          cyc_d    = 1'b0;
          rdata_d  = wb_dat_i;
          acc_done = 1'b1;
        end else if (wb_err_i) begin
          cyc_d    = 1'b0;
          rdata_d  = '0;
          status_d = StatErr;
          acc_done = 1'b1;
        end else if (wb_cnt_q == WbCntW'(WB_TIMEOUT - 1)) begin
          cyc_d    = 1'b0;
          rdata_d  = '0;
          status_d = StatTmo;
          acc_done = 1'b1;
        end else begin
          wb_cnt_d = wb_cnt_q + WbCntW'(1);
        end
        if (acc_done && !write_q) begin
          idx_d   = '0;
          state_d = StTxData;
        end
      end

      StTxData: begin
        if (tx_fire) begin
          if (last_dbyte) begin
            idx_d = '0;
            if (last_word) begin
              state_d = StTxStatus;
            end else begin
              word_d = word_q + 8'd1;
              addr_d = addr_next;
              if (status_q == StatOk) begin
                cyc_d    = 1'b1;
                wb_cnt_d = '0;
                state_d  = StWbAcc;
              end else begin
                // Skipped word after an error reads back as zeros
                rdata_d = '0;
              end
            end
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end

      StTxStatus: begin
        if (tx_fire) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase

    // Write word finished (issued or skipped): move to the next word or report
    if (acc_done && write_q) begin
      if (last_word) begin
        state_d = StTxStatus;
      end else begin
        word_d  = word_q + 8'd1;
        addr_d  = addr_next;
        wdata_d = '0;
        state_d = StWdata;
      end
    end

    // Inter-byte timeout abandons a partial frame silently
    if (rx_state && state_q != StIdle) begin
      if (rx_fire) begin
        rx_cnt_d = '0;
      end else if (rx_cnt_q == RxCntW'(RX_TIMEOUT - 1)) begin
        rx_cnt_d = '0;
        state_d  = StIdle;
      end else begin
        rx_cnt_d = rx_cnt_q + RxCntW'(1);
      end
    end else begin
      rx_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      write_q  <= 1'b0;
      addr_q   <= '0;
      len_q    <= '0;
      word_q   <= '0;
      idx_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      status_q <= StatOk;
      cyc_q    <= 1'b0;
      wb_cnt_q <= '0;
      rx_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      word_q   <= word_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      status_q <= status_d;
      cyc_q    <= cyc_d;
      wb_cnt_q <= wb_cnt_d;
      rx_cnt_q <= rx_cnt_d;
    end
  end

  always_comb begin
    tx_data = 8'h00;
    if (state_q == StTxData) begin
      tx_data = rdata_q[8*idx_q +: 8];
    end else if (state_q == StTxStatus) begin
      tx_data = status_q;
    end
  end

  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = cyc_q && write_q;
  assign wb_adr_o = cyc_q ? addr_q : '0;
  assign wb_dat_o = (cyc_q && write_q) ? wdata_q : '0;
  assign wb_sel_o = {BYTES{cyc_q}};
  assign busy     = state_q != StIdle;

endmodule
